core_cluster: RTL and testbench
===============================

CORE_CLUSTER -- requirements
Module: core_cluster

Interface
REQ-001 SHALL provide parameter NR_CORES, default 4, number of core instances (legal 1..16).
REQ-002 SHALL provide parameter BIT_WIDTH, default 8, core data width.
REQ-003 SHALL provide parameter GLOBAL_REGS, default 12, number of implemented global registers (legal 1..16).
REQ-004 SHALL provide parameter OUT_BITS, default 1, accumulator LSBs serialised per output command (legal 1..BIT_WIDTH).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port opcode  input  16  instruction word.
REQ-008 SHALL have port execute  input  1  opcode qualifier, one instruction per high cycle.
REQ-009 SHALL have port valid_bit  output  1  output_bit carries a serialised bit this cycle.
REQ-010 SHALL have port output_bit  output  1  serial data, LSB first.
REQ-011 SHALL have port busy  output  1  serialiser active.
REQ-012 SHALL have port core_en  output  NR_CORES  current core enable mask.

Function
REQ-013 SHALL instantiate NR_CORES existing core modules (CORE_ID = index, BIT_WIDTH), each with execute = core_en[i] & execute, all sharing opcode and the flattened 16-entry global register bus.
REQ-014 SHALL decode misc commands only when execute=1 and opcode[15:14]=11; the field sel=opcode[12:9] addresses global registers, and its low max(1,clog2(NR_CORES)) bits address cores.
REQ-015 opcode[6:5]: 01 -> core_en one-hot at sel; 10 -> all ones; 11 -> toggle core_en[sel] only; 00 -> no change; applied at the same clock edge.
REQ-016 Core select >= NR_CORES: 01 yields all-zero mask, 11 no change, serialiser start ignored.
REQ-017 opcode[7]=1 SHALL write global register sel with accumulator bits [BIT_WIDTH-1:0] of the lowest-index enabled core; no write if core_en is zero or sel >= GLOBAL_REGS.
REQ-018 Global store and core_en update in the same instruction SHALL use the pre-update core_en for source selection.
REQ-019 Flattened bus entries >= GLOBAL_REGS SHALL read zero.
REQ-020 opcode[4]=1 SHALL start the serialiser: capture accumulator bits [OUT_BITS-1:0] of core sel at edge N; valid_bit=1 with output_bit = bit k during cycle N+1+k, k=0..OUT_BITS-1.
REQ-021 busy SHALL equal valid_bit; the serialiser state machine has states IDLE and SHIFT with a down-counter of width clog2(OUT_BITS+1).
REQ-022 A start SHALL be accepted in IDLE or in the final SHIFT cycle (gapless back-to-back); a start in any other SHIFT cycle SHALL be dropped without disturbing the stream.
REQ-023 output_bit SHALL hold its last value when valid_bit=0.

Reset
REQ-024 rst_n low SHALL asynchronously force core_en all ones, global registers zero, serialiser IDLE, valid_bit=0, output_bit=0, busy=0.
REQ-025 Reset mid-stream SHALL abort the stream; no further valid_bit until a new start after release.
REQ-026 Core accumulator reset is the core modules' own behaviour and is not controlled here.

Configuration
REQ-027 With CORE_CLUSTER_READBACK_EN defined, opcode[3]=1 (opcode[4]=0) SHALL start the serialiser from global register sel bits [OUT_BITS-1:0] with REQ-020..022 timing; sel >= GLOBAL_REGS yields zeros.
REQ-028 Without CORE_CLUSTER_READBACK_EN, opcode[3] SHALL be ignored and no readback logic synthesised; if opcode[4] and opcode[3] are both set, opcode[4] wins.

Verification
REQ-029 Reset release, no execute -> core_en=4'b1111, valid_bit=0, busy=0, all global registers read 0.
REQ-030 Misc opcode[6:5]=01 sel=2, then 11 sel=0 -> core_en 4'b0100 then 4'b0101; then 11 sel=0 -> 4'b0100.
REQ-031 core_en=4'b0110, cores 1/2 accus 0x05/0x09, store sel=3 -> global reg 3 = 0x05; store sel=12 -> no write.
REQ-032 OUT_BITS=4, accu core1=0x0A, output sel=1 at cycle N -> valid_bit 1 cycles N+1..N+4, bits 0,1,0,1; second start at N+4 -> continuous valid; start at N+2 dropped.
REQ-033 rst_n low during cycle N+2 of a stream -> valid_bit=0 immediately, core_en=all ones, no residual bits.
REQ-034 CORE_CLUSTER_READBACK_EN defined, global reg 5 = 0x03, OUT_BITS=2, readback sel=5 -> bits 1,1; undefined -> no valid_bit.

Source files
------------

// File: rtl/core_cluster.sv
// -----------------------------------------------------------------------------
// core_cluster
//
// Purpose
//   A cluster of NR_CORES small accumulator cores. All cores share one
//   instruction stream and one set of global registers. Misc commands
//   (opcode[15:14] = 2'b11) are handled here. They manage the core enable
//   mask, store an accumulator into a global register, and start a serialiser
//   that shifts accumulator LSBs out one bit per cycle.
//
// Optional feature
//   CORE_CLUSTER_READBACK_EN : when defined, opcode[3] (with opcode[4] = 0)
//   starts the serialiser from global register sel instead of from a core.
//   When undefined, opcode[3] is ignored by the cluster and no readback logic
//   exists.
//
// Parameters
//   NR_CORES    : number of cores (1..16)
//   BIT_WIDTH   : core data width
//   GLOBAL_REGS : implemented global registers (1..16); higher entries read 0
//   OUT_BITS    : accumulator LSBs serialised per output command (1..BIT_WIDTH)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   16-bit instruction word
//   execute    in   instruction qualifier, one instruction per high cycle
//   valid_bit  out  output_bit carries a serialised bit this cycle
//   output_bit out  serial data, LSB first, holds its value while idle
//   busy       out  serialiser active (same as valid_bit)
//   core_en    out  current core enable mask
//
// Core instruction set (opcode[15:13]; sel = opcode[12:9], imm = opcode[7:0])
//   000 LDI  accu = imm        001 ADDI accu += imm
//   010 LDG  accu = greg[sel]  011 ADDG accu += greg[sel]
//   100 LDID accu = CORE_ID    101 SUBI accu -= imm
//   11x      misc command, handled by the cluster
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// core
//   One accumulator core. It executes only when its execute input is high.
//   Ports: clk, rst_n, opcode, execute, global_regs (16 flattened entries),
//          accu (current accumulator value).
// -----------------------------------------------------------------------------
module core #(
  parameter int CORE_ID   = 0,
  parameter int BIT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               opcode,
  input  logic                      execute,
  input  logic [16*BIT_WIDTH-1:0]   global_regs,
  output logic [BIT_WIDTH-1:0]      accu
);

  logic [BIT_WIDTH-1:0] accu_reg;
  logic [BIT_WIDTH-1:0] accu_next;
  logic [BIT_WIDTH-1:0] imm_ext;
  logic [BIT_WIDTH-1:0] greg_val;
  logic [3:0]           sel;
  logic                 unused_op_bit;

  assign sel           = opcode[12:9];
  assign unused_op_bit = opcode[8];

  // The 8-bit immediate is zero-extended, or truncated, to the data width.
  always_comb begin
    imm_ext = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (i < 8) imm_ext[i] = opcode[i];
    end
  end

  always_comb begin
    greg_val = '0;
    for (int i = 0; i < 16; i++) begin
      if (sel == 4'(i)) greg_val = global_regs[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_comb begin
    accu_next = accu_reg;
    if (execute) begin
      case (opcode[15:13])
        3'b000:  accu_next = imm_ext;
        3'b001:  accu_next = accu_reg + imm_ext;
        3'b010:  accu_next = greg_val;
        3'b011:  accu_next = accu_reg + greg_val;
        3'b100:  accu_next = BIT_WIDTH'(CORE_ID);
        3'b101:  accu_next = accu_reg - imm_ext;
        default: accu_next = accu_reg;   // misc commands do not touch the core
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) accu_reg <= '0;
    else        accu_reg <= accu_next;
  end

  assign accu = accu_reg;

endmodule

// -----------------------------------------------------------------------------
// core_cluster top
// -----------------------------------------------------------------------------
module core_cluster #(
  parameter int NR_CORES    = 4,
  parameter int BIT_WIDTH   = 8,
  parameter int GLOBAL_REGS = 12,
  parameter int OUT_BITS    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         opcode,
  input  logic                execute,
  output logic                valid_bit,
  output logic                output_bit,
  output logic                busy,
  output logic [NR_CORES-1:0] core_en
);

  localparam int CSEL_W = (NR_CORES > 1) ? $clog2(NR_CORES) : 1;
  localparam int CNT_W  = $clog2(OUT_BITS + 1);

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  // Cluster state
  logic [NR_CORES-1:0]     core_en_reg, core_en_next;
  logic [BIT_WIDTH-1:0]    greg_reg [GLOBAL_REGS];
  ser_state_t              state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [OUT_BITS-1:0]     shift_reg;
  logic                    valid_reg;
  logic                    out_reg;

  // Datapath wiring
  logic [BIT_WIDTH-1:0]    accu [NR_CORES];
  logic [16*BIT_WIDTH-1:0] greg_bus;

  // Decode
  logic                    misc;
  logic [3:0]              sel;
  logic [CSEL_W-1:0]       core_sel;
  logic [NR_CORES-1:0]     core_hit;
  logic                    core_sel_ok;
  logic                    greg_sel_ok;
  logic [OUT_BITS-1:0]     core_bits;
  logic [BIT_WIDTH-1:0]    store_src;
  logic                    store_we;
  logic                    start_req;
  logic [OUT_BITS-1:0]     start_bits;
  logic                    last_shift;
  logic                    accept;

  assign misc     = execute & (opcode[15:14] == 2'b11);
  assign sel      = opcode[12:9];
  assign core_sel = sel[CSEL_W-1:0];

  // ---------------------------------------------------------------------------
  // Global register bus. Entries at or above GLOBAL_REGS are tied to zero.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bus
      if (gi < GLOBAL_REGS) begin : g_impl
        assign greg_bus[gi*BIT_WIDTH +: BIT_WIDTH] = greg_reg[gi];
      end else begin : g_zero
        assign greg_bus[gi*BIT_WIDTH +: BIT_WIDTH] = '0;
      end
    end

    for (gi = 0; gi < NR_CORES; gi++) begin : g_core
      core #(
        .CORE_ID   (gi),
        .BIT_WIDTH (BIT_WIDTH)
      ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .execute     (core_en_reg[gi] & execute),
        .global_regs (greg_bus),
        .accu        (accu[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Core select decode. With a non-power-of-two core count, some select codes
  // match no core. Such a code gives core_hit = 0 and core_sel_ok = 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    core_hit    = '0;
    core_sel_ok = 1'b0;
    core_bits   = '0;
    for (int i = 0; i < NR_CORES; i++) begin
      if (core_sel == CSEL_W'(i)) begin
        core_hit[i] = 1'b1;
        core_sel_ok = 1'b1;
        core_bits   = accu[i][OUT_BITS-1:0];
      end
    end
  end

  always_comb begin
    greg_sel_ok = 1'b0;
    for (int i = 0; i < GLOBAL_REGS; i++) begin
      if (sel == 4'(i)) greg_sel_ok = 1'b1;
    end
  end

  // The store source is the lowest-index enabled core under the current mask.
  // The mask update in the same instruction has not been applied yet. The
  // descending loop leaves the lowest set index last, so that index wins.
  always_comb begin
    store_src = '0;
    for (int i = NR_CORES - 1; i >= 0; i--) begin
      if (core_en_reg[i]) store_src = accu[i];
    end
  end

  assign store_we = misc & opcode[7] & (|core_en_reg) & greg_sel_ok;

  // ---------------------------------------------------------------------------
  // Enable mask update
  // ---------------------------------------------------------------------------
  always_comb begin
    core_en_next = core_en_reg;
    if (misc) begin
      case (opcode[6:5])
        2'b01:   core_en_next = core_hit;                // one-hot, or zero if no such core
        2'b10:   core_en_next = '1;
        2'b11:   core_en_next = core_en_reg ^ core_hit;  // unmatched select leaves mask alone
        default: core_en_next = core_en_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_en_reg <= '1;
    else        core_en_reg <= core_en_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GLOBAL_REGS; i++) greg_reg[i] <= '0;
    end else begin
      for (int i = 0; i < GLOBAL_REGS; i++) begin
        if (store_we && (sel == 4'(i))) greg_reg[i] <= store_src;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser start selection
  // ---------------------------------------------------------------------------
`ifdef CORE_CLUSTER_READBACK_EN
  logic                rb_req;
  logic [OUT_BITS-1:0] rb_bits;

  // A select beyond the implemented registers leaves rb_bits at zero,
  // so it streams zeros.
  always_comb begin
    rb_bits = '0;
    for (int i = 0; i < GLOBAL_REGS; i++) begin
      if (sel == 4'(i)) rb_bits = greg_reg[i][OUT_BITS-1:0];
    end
  end

  assign rb_req     = misc & opcode[3] & ~opcode[4];
  assign start_req  = (misc & opcode[4] & core_sel_ok) | rb_req;
  assign start_bits = opcode[4] ? core_bits : rb_bits;
`else
  assign start_req  = misc & opcode[4] & core_sel_ok;
  assign start_bits = core_bits;
`endif

  // A new start is taken in IDLE or in the final SHIFT cycle. The final-cycle
  // case lets back-to-back streams run with no gap. A start in any earlier
  // SHIFT cycle is dropped.
  assign last_shift = (state_reg == SHIFT) && (cnt_reg == CNT_W'(1));
  assign accept     = start_req && ((state_reg == IDLE) || last_shift);

  // ---------------------------------------------------------------------------
  // Serialiser FSM. Bit 0 is presented in the cycle after capture.
  // cnt_reg counts the bits still to show, including the one on the output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      out_reg   <= 1'b0;
    end else if (accept) begin
      state_reg <= SHIFT;
      cnt_reg   <= CNT_W'(OUT_BITS);
      shift_reg <= start_bits >> 1;
      valid_reg <= 1'b1;
      out_reg   <= start_bits[0];
    end else begin
      case (state_reg)
        SHIFT: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;          // out_reg keeps the last bit
          end else begin
            cnt_reg   <= cnt_reg - CNT_W'(1);
            out_reg   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign valid_bit  = valid_reg;
  assign busy       = valid_reg;
  assign output_bit = out_reg;
  assign core_en    = core_en_reg;

endmodule

// File: tb/tb_core_cluster.sv
// -----------------------------------------------------------------------------
// tb_core_cluster
//   Directed test of core_cluster with NR_CORES=4, BIT_WIDTH=8,
//   GLOBAL_REGS=12 and OUT_BITS=4. Expected values are worked out by hand.
//   Inputs change on the falling edge. Outputs are sampled on the next
//   falling edge, after the rising edge that applied the instruction.
// -----------------------------------------------------------------------------
module tb_core_cluster;

  logic        clk;
  logic        rst_n;
  logic [15:0] opcode;
  logic        execute;
  logic        valid_bit;
  logic        output_bit;
  logic        busy;
  logic [3:0]  core_en;

  int total_cnt = 0;
  int bad_cnt   = 0;

  core_cluster #(
    .NR_CORES    (4),
    .BIT_WIDTH   (8),
    .GLOBAL_REGS (12),
    .OUT_BITS    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .execute    (execute),
    .valid_bit  (valid_bit),
    .output_bit (output_bit),
    .busy       (busy),
    .core_en    (core_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misc_op(input logic [3:0] sel, input logic [1:0] mode,
                                          input logic st, input logic out, input logic rb);
    return {2'b11, 1'b0, sel, 1'b0, st, mode, out, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [7:0] v);
    return {3'b000, 5'b00000, v};
  endfunction

  // One instruction per cycle. The task returns on the falling edge after the
  // rising edge that applied the instruction.
  task automatic step(input logic [15:0] op, input logic ex);
    opcode  = op;
    execute = ex;
    @(negedge clk);
    $display("t=%0t op=%h ex=%b core_en=%b valid=%b bit=%b busy=%b",
             $time, op, ex, core_en, valid_bit, output_bit, busy);
  endtask

  task automatic idle();
    step(16'h0000, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic b);
    check({tag, "_valid"}, 32'(valid_bit), 32'(v));
    check({tag, "_busy"},  32'(busy),      32'(v));
    check({tag, "_bit"},   32'(output_bit), 32'(b));
  endtask

  // Issue a start and check the four streamed bits. Then check that the
  // stream ends and the output holds its last bit.
  task automatic stream(input string tag, input logic [15:0] op, input logic [3:0] bits);
    step(op, 1'b1);
    chk_out({tag, "_k0"}, 1'b1, bits[0]);
    idle(); chk_out({tag, "_k1"}, 1'b1, bits[1]);
    idle(); chk_out({tag, "_k2"}, 1'b1, bits[2]);
    idle(); chk_out({tag, "_k3"}, 1'b1, bits[3]);
    idle(); chk_out({tag, "_end"}, 1'b0, bits[3]);
  endtask

  initial begin
    rst_n   = 1'b0;
    opcode  = '0;
    execute = 1'b0;

    // ---- Reset state ----
    @(negedge clk);
    @(negedge clk);
    check("rst_core_en", 32'(core_en), 32'hF);
    chk_out("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    idle();
    idle();
    check("rel_core_en", 32'(core_en), 32'hF);
    chk_out("rel", 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) check($sformatf("rel_greg%0d", i), 32'(dut.greg_reg[i]), 32'h0);

    // ---- Enable mask commands ----
    step(misc_op(4'd2, 2'b01, 1'b0, 1'b0, 1'b0), 1'b1);
    check("en_onehot2", 32'(core_en), 32'b0100);
    step(misc_op(4'd0, 2'b11, 1'b0, 1'b0, 1'b0), 1'b1);
    check("en_toggle0_on", 32'(core_en), 32'b0101);
    step(misc_op(4'd0, 2'b11, 1'b0, 1'b0, 1'b0), 1'b1);
    check("en_toggle0_off", 32'(core_en), 32'b0100);
    step(misc_op(4'd7, 2'b01, 1'b0, 1'b0, 1'b0), 1'b1);   // low select bits -> core 3
    check("en_onehot_sel7", 32'(core_en), 32'b1000);
    step(misc_op(4'd0, 2'b10, 1'b0, 1'b0, 1'b0), 1'b1);
    check("en_all", 32'(core_en), 32'b1111);
    step(misc_op(4'd1, 2'b00, 1'b0, 1'b0, 1'b0), 1'b1);
    check("en_nochange", 32'(core_en), 32'b1111);
    step(misc_op(4'd1, 2'b01, 1'b0, 1'b0, 1'b0), 1'b0);   // execute low: ignored
    check("en_no_execute", 32'(core_en), 32'b1111);

    // ---- Global store ----
    step(misc_op(4'd1, 2'b01, 1'b0, 1'b0, 1'b0), 1'b1);
    step(ldi(8'h05), 1'b1);                                // core1 = 0x05
    step(misc_op(4'd2, 2'b01, 1'b0, 1'b0, 1'b0), 1'b1);
    step(ldi(8'h09), 1'b1);                                // core2 = 0x09
    step(misc_op(4'd1, 2'b11, 1'b0, 1'b0, 1'b0), 1'b1);
    check("st_mask", 32'(core_en), 32'b0110);
    step(misc_op(4'd3, 2'b00, 1'b1, 1'b0, 1'b0), 1'b1);
    check("st_greg3", 32'(dut.greg_reg[3]), 32'h05);
    step(misc_op(4'd12, 2'b00, 1'b1, 1'b0, 1'b0), 1'b1);   // no such register
    check("st12_greg3", 32'(dut.greg_reg[3]), 32'h05);
    check("st12_greg11", 32'(dut.greg_reg[11]), 32'h00);
    check("st12_greg0", 32'(dut.greg_reg[0]), 32'h00);
    // Store and mask update together: the source is core1 from the old mask.
    step(misc_op(4'd0, 2'b01, 1'b1, 1'b0, 1'b0), 1'b1);
    check("st_pre_greg0", 32'(dut.greg_reg[0]), 32'h05);
    check("st_pre_mask", 32'(core_en), 32'b0001);
    step(misc_op(4'd0, 2'b11, 1'b0, 1'b0, 1'b0), 1'b1);
    check("st_zero_mask", 32'(core_en), 32'b0000);
    step(misc_op(4'd3, 2'b00, 1'b1, 1'b0, 1'b0), 1'b1);    // empty mask: no write
    check("st_zero_greg3", 32'(dut.greg_reg[3]), 32'h05);

    // ---- Serialiser: core1 = 0x0A, core2 = 0x09 ----
    step(misc_op(4'd1, 2'b01, 1'b0, 1'b0, 1'b0), 1'b1);
    step(ldi(8'h0A), 1'b1);
    chk_out("ser_pre", 1'b0, 1'b0);
    step(misc_op(4'd1, 2'b00, 1'b0, 1'b1, 1'b0), 1'b1);    // edge N
    chk_out("ser_n1", 1'b1, 1'b0);
    idle();
    chk_out("ser_n2", 1'b1, 1'b1);
    step(misc_op(4'd2, 2'b00, 1'b0, 1'b1, 1'b0), 1'b1);    // mid-stream start, dropped
    chk_out("ser_n3", 1'b1, 1'b0);
    idle();
    chk_out("ser_n4", 1'b1, 1'b1);
    step(misc_op(4'd2, 2'b00, 1'b0, 1'b1, 1'b0), 1'b1);    // final-cycle start, taken
    chk_out("ser_b2b_k0", 1'b1, 1'b1);
    idle(); chk_out("ser_b2b_k1", 1'b1, 1'b0);
    idle(); chk_out("ser_b2b_k2", 1'b1, 1'b0);
    idle(); chk_out("ser_b2b_k3", 1'b1, 1'b1);
    idle(); chk_out("ser_done", 1'b0, 1'b1);
    idle(); chk_out("ser_hold", 1'b0, 1'b1);

    // ---- Reset during a stream ----
    step(misc_op(4'd1, 2'b00, 1'b0, 1'b1, 1'b0), 1'b1);
    chk_out("ab_n1", 1'b1, 1'b0);
    idle();
    chk_out("ab_n2", 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("ab_rst", 1'b0, 1'b0);
    check("ab_core_en", 32'(core_en), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      chk_out($sformatf("ab_after%0d", i), 1'b0, 1'b0);
    end
    check("ab_greg3", 32'(dut.greg_reg[3]), 32'h00);

    // ---- Readback / opcode[4] priority ----
    step(misc_op(4'd0, 2'b01, 1'b0, 1'b0, 1'b0), 1'b1);
    step(ldi(8'h03), 1'b1);                                // core0 = 0x03
    step(misc_op(4'd5, 2'b00, 1'b1, 1'b0, 1'b0), 1'b1);
    check("rb_greg5", 32'(dut.greg_reg[5]), 32'h03);
    step(misc_op(4'd1, 2'b01, 1'b0, 1'b0, 1'b0), 1'b1);
    step(ldi(8'h0C), 1'b1);                                // core1 = 0x0C
`ifdef CORE_CLUSTER_READBACK_EN
    stream("rb5", misc_op(4'd5, 2'b00, 1'b0, 1'b0, 1'b1), 4'b0011);
    stream("rb13", misc_op(4'd13, 2'b00, 1'b0, 1'b0, 1'b1), 4'b0000);
`else
    step(misc_op(4'd5, 2'b00, 1'b0, 1'b0, 1'b1), 1'b1);
    chk_out("norb_k0", 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      idle();
      chk_out($sformatf("norb_k%0d", i), 1'b0, 1'b0);
    end
`endif
    // opcode[4] and opcode[3] both set: core1 data (0x0C) is streamed
    stream("prio", misc_op(4'd5, 2'b00, 1'b0, 1'b1, 1'b1), 4'b1100);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
